led_pattern_engine: RTL and testbench

Parametrised multi-mode LED pattern sequencer for the board LED bank. Advances one pattern step per qualified `tick` (from the shared slow-tick divider), so the block runs on the system clock with no derived clocks. It supports four selectable animations, pause, and a frame-boundary pulse for chaining with other display blocks. WIDTH=16, mode 0 reproduces the original centre-expand bar.

---
 rtl/led_pattern_engine.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// ---------------------------------------------------------------------------
// led_pattern_engine
//   Multi-mode LED pattern sequencer for the board LED bank. One pattern step
//   is taken per qualified tick from the shared slow-tick divider, so
//   everything runs on clk with no derived clocks.
//
//   Animations (mode):
//     0 EXPAND   : centre-out bar, step 0..HALF, then wrap
//     1 PINGPONG : same bar, step 0..HALF..0, endpoints shown once
//     2 BOUNCE   : single lit LED, step 0..WIDTH-1..0
//     3 FILL     : right-aligned fill, step 0..WIDTH, then wrap
//
// Parameters:
//   WIDTH : number of LEDs, even and at least 4.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   tick  in   step enable, one step per high cycle
//   pause in   hold current step while high (tick ignored)
//   mode  in   animation select
//   led   out  registered LED drive, bit 0 is the rightmost LED
//   frame out  one-cycle pulse when the pattern returns to step 0
//   step  out  current step index (debug view of the sequencer state)
//
// Handshake: there is none. tick is a plain enable, sampled on every rising
// clk edge; it is consumed only when pause is low and mode equals the
// registered mode. A mode change always wins over tick and pause.
//
// Build option:
//   LED_PATTERN_ACTIVE_LOW_EN : when defined, led is the bitwise complement
//   of the pattern (reset value all ones) for active-low boards.
// ---------------------------------------------------------------------------
module led_pattern_engine #(
   parameter int WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick,
   input  logic                          pause,
   input  logic [1:0]                    mode,
   output logic [WIDTH-1:0]              led,
   output logic                          frame,
   output logic [$clog2(2*WIDTH)-1:0]    step
);

   localparam int HALF   = WIDTH / 2;
   localparam int STEP_W = $clog2(2 * WIDTH);

   localparam logic [STEP_W-1:0] HALF_S  = STEP_W'(HALF);
   localparam logic [STEP_W-1:0] LAST_S  = STEP_W'(WIDTH - 1);
   localparam logic [STEP_W-1:0] WIDTH_S = STEP_W'(WIDTH);

`ifdef LED_PATTERN_ACTIVE_LOW_EN
   localparam logic [WIDTH-1:0] LED_RST = '1;
`else
   localparam logic [WIDTH-1:0] LED_RST = '0;
`endif

   typedef enum logic [1:0] {
      MODE_EXPAND   = 2'd0,
      MODE_PINGPONG = 2'd1,
      MODE_BOUNCE   = 2'd2,
      MODE_FILL     = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   mode_t              mode_q, mode_d;
   dir_t               dir_q, dir_d, dir_nxt;
   logic [STEP_W-1:0]  step_q, step_d, step_nxt, turn_s;
   logic [WIDTH-1:0]   led_q, led_d;
   logic               frame_q, frame_d;

   // Active-high pattern for a given mode and step.
   function automatic logic [WIDTH-1:0] pattern(input mode_t m,
                                                input logic [STEP_W-1:0] s);
      logic [WIDTH-1:0] p;
      int               si;
      si = int'(s);
      p  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (m)
            MODE_EXPAND,
            MODE_PINGPONG: p[i] = (i >= HALF - si) && (i < HALF + si);
            MODE_BOUNCE:   p[i] = (i == si);
            default:       p[i] = (i < si);
         endcase
      end
      return p;
   endfunction

   // Board polarity is applied before the register so led stays a flop output.
   function automatic logic [WIDTH-1:0] drive(input logic [WIDTH-1:0] p);
`ifdef LED_PATTERN_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   // Step the current animation by one; only used when an advance happens.
   always_comb begin
      step_nxt = step_q;
      dir_nxt  = dir_q;
      turn_s   = (mode_q == MODE_PINGPONG) ? HALF_S : LAST_S;
      case (mode_q)
         MODE_EXPAND: step_nxt = (step_q == HALF_S)  ? '0 : step_q + STEP_W'(1);
         MODE_FILL:   step_nxt = (step_q == WIDTH_S) ? '0 : step_q + STEP_W'(1);
         default: begin
            // PINGPONG and BOUNCE: the direction flips on the edge that lands
            // on an endpoint, so each endpoint is displayed for one tick only.
            if (dir_q == DIR_UP) begin
               step_nxt = step_q + STEP_W'(1);
               if (step_nxt == turn_s) dir_nxt = DIR_DOWN;
            end else begin
               step_nxt = step_q - STEP_W'(1);
               if (step_nxt == '0) dir_nxt = DIR_UP;
            end
         end
      endcase
   end

   always_comb begin
      mode_d  = mode_q;
      step_d  = step_q;
      dir_d   = dir_q;
      led_d   = led_q;
      frame_d = 1'b0;
      if (mode != mode_q) begin
         // Restart the new animation; the tick on this edge is not consumed.
         mode_d = mode_t'(mode);
         step_d = '0;
         dir_d  = DIR_UP;
         led_d  = drive(pattern(mode_t'(mode), '0));
      end else if (tick && !pause) begin
         step_d  = step_nxt;
         dir_d   = dir_nxt;
         led_d   = drive(pattern(mode_q, step_nxt));
         frame_d = (step_nxt == '0) && (step_q != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_EXPAND;
         step_q  <= '0;
         dir_q   <= DIR_UP;
         led_q   <= LED_RST;
         frame_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         led_q   <= led_d;
         frame_q <= frame_d;
      end
   end

   assign led   = led_q;
   assign frame = frame_q;
   assign step  = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_engine
//   Self-checking bench for led_pattern_engine at WIDTH 16. The reference
//   model describes each animation as a looped list of step values indexed
//   by a position counter; LED values are computed arithmetically from the
//   step. Directed scenarios come first, then a randomized run.
// ---------------------------------------------------------------------------
module tb_led_pattern_engine;

   localparam int WIDTH = 16;
   localparam int HALF  = WIDTH / 2;
   localparam int SW    = $clog2(2 * WIDTH);

   logic             clk;
   logic             rst;
   logic             tick;
   logic             pause;
   logic [1:0]       mode;
   logic [WIDTH-1:0] led;
   logic             frame;
   logic [SW-1:0]    step;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_mode;
   int m_idx;
   bit m_frame;

   led_pattern_engine #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .pause (pause),
      .mode  (mode),
      .led   (led),
      .frame (frame),
      .step  (step)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic int seq_len(int m);
      case (m)
         0:       return HALF + 1;
         1:       return 2 * HALF;
         2:       return 2 * (WIDTH - 1);
         default: return WIDTH + 1;
      endcase
   endfunction

   function automatic int seq_at(int m, int idx);
      case (m)
         1:       return (idx <= HALF) ? idx : 2 * HALF - idx;
         2:       return (idx <= WIDTH - 1) ? idx : 2 * (WIDTH - 1) - idx;
         default: return idx;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] drv(logic [WIDTH-1:0] p);
`ifdef LED_PATTERN_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] led_of(int m, int s);
      longint unsigned v;
      case (m)
         0, 1:    v = ((64'd1 << (2 * s)) - 64'd1) << (HALF - s);
         2:       v = 64'd1 << s;
         default: v = (64'd1 << s) - 64'd1;
      endcase
      return drv(v[WIDTH-1:0]);
   endfunction

   // ---------------- driver ----------------
   task automatic cycle(input bit t, input bit p, input logic [1:0] m);
      tick  = t;
      pause = p;
      mode  = m;
      @(posedge clk);
      if (int'(m) != m_mode) begin
         m_mode  = int'(m);
         m_idx   = 0;
         m_frame = 1'b0;
      end else if (t && !p) begin
         m_idx   = (m_idx + 1) % seq_len(m_mode);
         m_frame = (m_idx == 0);
      end else begin
         m_frame = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_idx   = 0;
      m_frame = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_all(input string tag);
      logic [SW-1:0]    exp_step;
      logic [WIDTH-1:0] exp_led;
      exp_step = SW'(seq_at(m_mode, m_idx));
      exp_led  = led_of(m_mode, seq_at(m_mode, m_idx));
      checks++;
      assert (step === exp_step) else begin
         errors++;
         $error("FAIL %s step got %0d exp %0d", tag, step, exp_step);
      end
      checks++;
      assert (led === exp_led) else begin
         errors++;
         $error("FAIL %s led got %h exp %h", tag, led, exp_led);
      end
      checks++;
      assert (frame === m_frame) else begin
         errors++;
         $error("FAIL %s frame got %b exp %b", tag, frame, m_frame);
      end
   endtask

   task automatic check_led(input string tag, input logic [WIDTH-1:0] exp);
      checks++;
      assert (led === exp) else begin
         errors++;
         $error("FAIL %s led got %h exp %h", tag, led, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %b exp %b", tag, got, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [WIDTH-1:0] expand_tbl [9];
   int               frame_cnt;
   logic [1:0]       rm;
   bit               rt, rp;

   initial begin
      expand_tbl = '{16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8,
                     16'h3FFC, 16'h7FFE, 16'hFFFF, 16'h0000};
      rst   = 1'b1;
      tick  = 1'b0;
      pause = 1'b0;
      mode  = 2'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      check_led("reset_const", drv(16'h0000));
      rst = 1'b0;
      @(negedge clk);

      // EXPAND with tick held high, against the literal table
      for (int k = 0; k < 9; k++) begin
         cycle(1'b1, 1'b0, 2'd0);
         check_all("expand");
         check_led("expand_tbl", drv(expand_tbl[k]));
         check_bit("expand_frame", frame, k == 8);
      end

      // PINGPONG, 20 ticks; exactly one frame pulse expected (at tick 16)
      cycle(1'b1, 1'b0, 2'd1);
      check_all("pp_enter");
      frame_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 2'd1);
         check_all("pingpong");
         if (frame) frame_cnt++;
         if (k == 15) check_bit("pp_frame16", frame, 1'b1);
      end
      checks++;
      assert (frame_cnt === 1) else begin
         errors++;
         $error("FAIL pp_frame_count got %0d exp 1", frame_cnt);
      end

      // BOUNCE, a full period plus a few
      cycle(1'b0, 1'b0, 2'd2);
      check_all("bounce_enter");
      for (int k = 0; k < 34; k++) begin
         cycle(1'b1, 1'b0, 2'd2);
         check_all("bounce");
      end

      // FILL with pause at step 4
      cycle(1'b0, 1'b0, 2'd3);
      check_all("fill_enter");
      repeat (4) cycle(1'b1, 1'b0, 2'd3);
      check_led("fill_step4", drv(16'h000F));
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b1, 2'd3);
         check_all("fill_pause");
         check_led("fill_hold", drv(16'h000F));
      end
      cycle(1'b1, 1'b0, 2'd3);
      check_all("fill_resume");
      check_led("fill_resume_const", drv(16'h001F));

      // Mode change coinciding with tick at BOUNCE step 5
      cycle(1'b0, 1'b0, 2'd2);
      repeat (5) cycle(1'b1, 1'b0, 2'd2);
      check_all("bounce_step5");
      cycle(1'b1, 1'b0, 2'd3);
      check_all("mode_chg");
      check_led("mode_chg_const", drv(16'h0000));
      check_bit("mode_chg_frame", frame, 1'b0);
      cycle(1'b1, 1'b0, 2'd3);
      check_all("mode_chg_next");
      check_led("mode_chg_next_const", drv(16'h0001));

      // Randomized run
      for (int k = 0; k < 400; k++) begin
         rm = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_mode);
         rt = ($urandom_range(0, 9) < 7);
         rp = ($urandom_range(0, 4) == 0);
         cycle(rt, rp, rm);
         check_all("rand");
      end

      // Asynchronous reset mid-sequence, checked before any clock edge
      repeat (5) cycle(1'b1, 1'b0, 2'd0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      check_led("async_rst_const", drv(16'h0000));
      mode = 2'd2;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 1'b0, 2'd2);
      check_all("rst_mode_chg");
      check_led("rst_mode_chg_const", drv(16'h0001));
      cycle(1'b1, 1'b0, 2'd2);
      check_all("rst_mode_next");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
